// File: rtl/gs_pipe_ctrl.sv
// GoldenSnitch pipeline controller: boot/fetch/decode sequencing, redirect flushes,
// stage holds, priority operand forwarding, debug halt with drain, sticky load timeout.
package gs_pkg;
    localparam logic [3:0] PC_BOOT   = 4'b0001;
    localparam logic [3:0] PC_NORMAL = 4'b0010;
    localparam logic [3:0] PC_BRANCH = 4'b0100;
    localparam logic [3:0] PC_JUMP   = 4'b1000;
endpackage

module gs_pipe_ctrl
    import gs_pkg::*;
#(
    parameter int NUM_RS       = 2,
    parameter int NUM_FWD      = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int LOAD_TIMEOUT = 15,
    localparam int FWD_W       = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_fetch_ready_i,
    input  logic                      id_ready_i,
    input  logic                      id_uncod_jumps_i,
    input  logic                      ex_br_taken_i,
    input  logic                      load_to_use_i,
    input  logic                      is_loading_i,
    input  logic [NUM_RS*NUM_FWD-1:0] fwd_hit_i,
    input  logic                      dbg_halt_req_i,
    input  logic                      dbg_resume_i,
    output logic [NUM_RS*FWD_W-1:0]   fwd_sel_o,
    output logic [3:0]                pc_mux_sel_o,
    output logic                      instr_fetch_o,
    output logic                      is_decoding_o,
    output logic                      flush_if_o,
    output logic                      flush_id_o,
    output logic                      flush_ex_o,
    output logic                      halt_if_o,
    output logic                      halt_id_o,
    output logic                      halt_ex_o,
    output logic                      dbg_halt_ack_o,
    output logic                      load_timeout_o
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int LOAD_W  = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        RESET, BOOT_SET, FIRST_FETCH, DECODE, WAIT_FETCH, DBG_DRAIN, DBG_HALTED
    } state_t;

    state_t             state_reg, state_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [LOAD_W-1:0]  load_cnt_reg, load_cnt_next;
    logic               ack_reg, ack_next;
    logic               timeout_reg, timeout_next;
    logic               hold_if, hold_id, hold_ex;
    logic               drain_idle;

    assign drain_idle = !is_loading_i && !load_to_use_i;

    always_comb begin
        state_next    = state_reg;
        pc_mux_sel_o  = PC_NORMAL;
        instr_fetch_o = 1'b0;
        is_decoding_o = 1'b0;
        flush_if_o    = 1'b0;
        flush_id_o    = 1'b0;
        flush_ex_o    = 1'b0;
        hold_if       = 1'b0;
        hold_id       = 1'b0;
        hold_ex       = 1'b0;
        case (state_reg)
            RESET: begin
                pc_mux_sel_o = PC_BOOT;
                state_next   = BOOT_SET;
            end
            BOOT_SET: begin
                pc_mux_sel_o  = PC_BOOT;
                instr_fetch_o = 1'b1;
                state_next    = FIRST_FETCH;
            end
            FIRST_FETCH, WAIT_FETCH: begin
                if (if_fetch_ready_i && id_ready_i) state_next = DECODE;
            end
            DECODE: begin
                // An outstanding load defers every redirect and debug request.
                if (!is_loading_i) begin
                    if (ex_br_taken_i) begin
                        pc_mux_sel_o = PC_BRANCH;
                        flush_if_o   = 1'b1;
                        flush_id_o   = 1'b1;
                    end else if (id_uncod_jumps_i) begin
                        pc_mux_sel_o = PC_JUMP;
                        flush_if_o   = 1'b1;
                        flush_id_o   = 1'b1;
                        state_next   = WAIT_FETCH;
                    end else if (dbg_halt_req_i) begin
                        flush_if_o = 1'b1;
                        state_next = DBG_DRAIN;
                    end else begin
                        is_decoding_o = 1'b1;
                    end
                end
            end
            DBG_DRAIN: begin
                hold_if = 1'b1;
                if (drain_idle && drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1))
                    state_next = DBG_HALTED;
            end
            DBG_HALTED: begin
                hold_if = 1'b1;
                hold_id = 1'b1;
                hold_ex = 1'b1;
                if (dbg_resume_i) begin
                    instr_fetch_o = 1'b1;
                    flush_ex_o    = 1'b1;
                    state_next    = WAIT_FETCH;
                end
            end
            default: state_next = RESET;
        endcase
        if (state_reg != RESET && state_reg != BOOT_SET) begin
            hold_if = hold_if | load_to_use_i | is_loading_i;
            hold_id = hold_id | load_to_use_i | is_loading_i;
            hold_ex = hold_ex | is_loading_i;
        end
    end

    // A flushed stage must not also be held.
    assign halt_if_o = hold_if & ~flush_if_o;
    assign halt_id_o = hold_id & ~flush_id_o;
    assign halt_ex_o = hold_ex & ~flush_ex_o;

    always_comb begin
        drain_cnt_next = '0;
        if (state_reg == DBG_DRAIN && state_next == DBG_DRAIN && drain_idle)
            drain_cnt_next = drain_cnt_reg + 1'b1;
        load_cnt_next = '0;
        if (is_loading_i)
            load_cnt_next = (load_cnt_reg == LOAD_W'(LOAD_TIMEOUT)) ? load_cnt_reg
                                                                    : load_cnt_reg + 1'b1;
        timeout_next = timeout_reg | (load_cnt_reg == LOAD_W'(LOAD_TIMEOUT));
        ack_next     = (state_reg == DBG_HALTED) && !dbg_resume_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RESET;
            drain_cnt_reg <= '0;
            load_cnt_reg  <= '0;
            ack_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            load_cnt_reg  <= load_cnt_next;
            ack_reg       <= ack_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign dbg_halt_ack_o = ack_reg;
    assign load_timeout_o = timeout_reg;

    // Lowest-numbered (youngest) matching source wins; forced to zero while in reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_fwd
            logic [FWD_W-1:0] sel;
            always_comb begin
                sel = '0;
                for (int s = NUM_FWD - 1; s >= 0; s--)
                    if (fwd_hit_i[gi*NUM_FWD + s]) sel = FWD_W'(s + 1);
            end
            assign fwd_sel_o[gi*FWD_W +: FWD_W] = rst ? sel : '0;
        end
    endgenerate
endmodule

// File: tb/tb_gs_pipe_ctrl.sv
// Bench for gs_pipe_ctrl: directed scenarios plus random cycles checked against a
// cycle-level behavioural model; a second 3x3 instance exercises wider forwarding.
module tb_gs_pipe_ctrl;
    import gs_pkg::*;

    localparam int DRAIN = 3;
    localparam int LTO   = 15;
    localparam int S_RST = 0, S_BOOT = 1, S_FF = 2, S_DEC = 3, S_WF = 4, S_DRN = 5, S_HLT = 6;

    logic       clk = 1'b0;
    logic       rst, fr, idr, jmp, br, ltu, ld, dbg, res;
    logic [3:0] hit;
    logic [8:0] hit3;

    logic [3:0] fwd2, pc, pc3;
    logic [5:0] fwd3;
    logic       fetch, dec, fl_if, fl_id, fl_ex, h_if, h_id, h_ex, ack, tmo;
    logic       fetch3, dec3, fl_if3, fl_id3, fl_ex3, h_if3, h_id3, h_ex3, ack3, tmo3;

    int n_pass  = 0;
    int n_total = 0;

    int m_st, m_idle, m_load;
    bit m_ack, m_tmo;

    always #5 clk = ~clk;

    gs_pipe_ctrl dut (
        .clk(clk), .rst(rst), .if_fetch_ready_i(fr), .id_ready_i(idr),
        .id_uncod_jumps_i(jmp), .ex_br_taken_i(br), .load_to_use_i(ltu),
        .is_loading_i(ld), .fwd_hit_i(hit), .dbg_halt_req_i(dbg), .dbg_resume_i(res),
        .fwd_sel_o(fwd2), .pc_mux_sel_o(pc), .instr_fetch_o(fetch), .is_decoding_o(dec),
        .flush_if_o(fl_if), .flush_id_o(fl_id), .flush_ex_o(fl_ex),
        .halt_if_o(h_if), .halt_id_o(h_id), .halt_ex_o(h_ex),
        .dbg_halt_ack_o(ack), .load_timeout_o(tmo)
    );

    gs_pipe_ctrl #(.NUM_RS(3), .NUM_FWD(3)) dut3 (
        .clk(clk), .rst(rst), .if_fetch_ready_i(fr), .id_ready_i(idr),
        .id_uncod_jumps_i(jmp), .ex_br_taken_i(br), .load_to_use_i(ltu),
        .is_loading_i(ld), .fwd_hit_i(hit3), .dbg_halt_req_i(dbg), .dbg_resume_i(res),
        .fwd_sel_o(fwd3), .pc_mux_sel_o(pc3), .instr_fetch_o(fetch3), .is_decoding_o(dec3),
        .flush_if_o(fl_if3), .flush_id_o(fl_id3), .flush_ex_o(fl_ex3),
        .halt_if_o(h_if3), .halt_id_o(h_id3), .halt_ex_o(h_ex3),
        .dbg_halt_ack_o(ack3), .load_timeout_o(tmo3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fwd_ref(input logic [31:0] h, input int nrs, input int nf);
        logic [31:0] r_val;
        r_val = '0;
        for (int r = 0; r < nrs; r++) begin
            int sel;
            sel = 0;
            for (int s = 0; s < nf; s++)
                if (sel == 0 && h[r*nf + s]) sel = s + 1;
            r_val = r_val | (32'(sel) << (2 * r));
        end
        return r_val;
    endfunction

    task automatic m_reset();
        m_st = S_RST; m_idle = 0; m_load = 0; m_ack = 0; m_tmo = 0;
    endtask

    task automatic m_advance();
        int nxt;
        if (!rst) begin
            m_reset();
            return;
        end
        m_tmo  = m_tmo || (m_load >= LTO);
        m_load = ld ? ((m_load < LTO) ? m_load + 1 : m_load) : 0;
        m_ack  = (m_st == S_HLT) && !res;
        nxt    = m_st;
        case (m_st)
            S_RST:      nxt = S_BOOT;
            S_BOOT:     nxt = S_FF;
            S_FF, S_WF: if (fr && idr) nxt = S_DEC;
            S_DEC: if (!ld && !br) begin
                if (jmp) nxt = S_WF;
                else if (dbg) nxt = S_DRN;
            end
            S_DRN: if (!ld && !ltu) begin
                m_idle++;
                if (m_idle == DRAIN) nxt = S_HLT;
            end else m_idle = 0;
            S_HLT: if (res) nxt = S_WF;
            default: nxt = S_RST;
        endcase
        if (nxt != S_DRN) m_idle = 0;
        m_st = nxt;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_pc;
        bit f, d, fi, fd, fe, hi, hd, he;
        logic [7:0] e_ctl;
        e_pc = PC_NORMAL;
        {f, d, fi, fd, fe, hi, hd, he} = '0;
        case (m_st)
            S_RST:  e_pc = PC_BOOT;
            S_BOOT: begin e_pc = PC_BOOT; f = 1; end
            S_DEC: if (!ld) begin
                if (br) begin e_pc = PC_BRANCH; fi = 1; fd = 1; end
                else if (jmp) begin e_pc = PC_JUMP; fi = 1; fd = 1; end
                else if (dbg) fi = 1;
                else d = 1;
            end
            S_DRN: hi = 1;
            S_HLT: begin
                {hi, hd, he} = 3'b111;
                if (res) begin f = 1; fe = 1; end
            end
            default: ;
        endcase
        if (m_st != S_RST && m_st != S_BOOT) begin
            hi = hi | ld | ltu;
            hd = hd | ld | ltu;
            he = he | ld;
        end
        e_ctl = {f, d, fi, fd, fe, hi & ~fi, hd & ~fd, he & ~fe};
        if (!rst) begin
            e_pc  = PC_BOOT;
            e_ctl = '0;
        end
        check({tag, ".pc"},   32'(pc),  32'(e_pc));
        check({tag, ".ctl"},  32'({fetch, dec, fl_if, fl_id, fl_ex, h_if, h_id, h_ex}), 32'(e_ctl));
        check({tag, ".ack"},  32'(ack), 32'(m_ack));
        check({tag, ".tmo"},  32'(tmo), 32'(m_tmo));
        check({tag, ".fwd"},  32'(fwd2), rst ? fwd_ref(32'(hit), 2, 2) : 32'd0);
        check({tag, ".pc3"},  32'(pc3), 32'(e_pc));
        check({tag, ".ctl3"}, 32'({fetch3, dec3, fl_if3, fl_id3, fl_ex3, h_if3, h_id3, h_ex3}), 32'(e_ctl));
        check({tag, ".ack3"}, 32'({ack3, tmo3}), 32'({m_ack, m_tmo}));
        check({tag, ".fwd3"}, 32'(fwd3), rst ? fwd_ref(32'(hit3), 3, 3) : 32'd0);
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        $display("[%0t] %s st=%0d pc=%h ctl=%b ack=%b tmo=%b fwd=%h/%h", $time, tag, m_st, pc,
                 {fetch, dec, fl_if, fl_id, fl_ex, h_if, h_id, h_ex}, ack, tmo, fwd2, fwd3);
        @(posedge clk);
        m_advance();
        #1;
    endtask

    initial begin
        rst = 0; fr = 1; idr = 1; jmp = 0; br = 0; ltu = 0; ld = 0; dbg = 0; res = 0;
        hit = 4'b1011; hit3 = 9'b111_000_110;
        m_reset();
        #1;
        check("fwd3_in_reset", 32'(fwd3), 32'd0);
        step("reset");
        step("reset_hold");

        // Boot sequence: RESET, BOOT_SET (fetch pulse), FIRST_FETCH, DECODE at cycle 3.
        rst = 1;
        step("boot_reset");
        step("boot_set");
        step("first_fetch");
        check("decode_at_3", 32'(dec), 32'd1);
        check("fwd3_plan", 32'(fwd3), 32'b01_00_10);
        check("fwd2_plan", 32'(fwd2), 32'b10_01);

        br = 1; jmp = 1; #1;
        check("br_pc", 32'(pc), 32'(PC_BRANCH));
        check("br_flush", 32'({fl_if, fl_id, fl_ex}), 32'b110);
        step("br_and_jump");
        ld = 1; #1;
        check("ld_defer_flush", 32'({fl_if, fl_id, fl_ex}), 32'b000);
        check("ld_defer_halt", 32'({h_if, h_id, h_ex}), 32'b111);
        step("br_deferred");
        ld = 0; br = 0;
        step("jump");
        jmp = 0;
        step("wait_fetch");

        // Debug halt: request, 2 loading cycles, 3 idle cycles, then the ack register.
        dbg = 1;
        step("dbg_req");
        ld = 1;
        step("drain_ld0");
        step("drain_ld1");
        ld = 0;
        step("drain_idle0");
        step("drain_idle1");
        step("drain_idle2");
        check("ack_not_yet", 32'(ack), 32'd0);
        step("halted");
        check("ack_at_7", 32'(ack), 32'd1);
        dbg = 0;
        step("halted_req_low");
        check("ack_holds", 32'(ack), 32'd1);
        res = 1; #1;
        check("resume_flush_fetch", 32'({fl_ex, fetch, h_ex}), 32'b110);
        step("resume");
        res = 0;
        check("ack_cleared", 32'(ack), 32'd0);
        step("refetch");

        // Load timeout: 15 consecutive loading cycles, flag on the following edge.
        ld = 1;
        for (int i = 0; i < LTO; i++) step("loading");
        check("tmo_not_yet", 32'(tmo), 32'd0);
        ld = 0;
        step("load_done");
        check("tmo_set", 32'(tmo), 32'd1);
        step("tmo_sticky0");
        step("tmo_sticky1");
        check("tmo_sticky", 32'(tmo), 32'd1);

        for (int i = 0; i < 300; i++) begin
            fr   = ($urandom_range(0, 3) != 0);
            idr  = ($urandom_range(0, 3) != 0);
            br   = ($urandom_range(0, 6) == 0);
            jmp  = ($urandom_range(0, 6) == 0);
            ltu  = ($urandom_range(0, 4) == 0);
            ld   = ($urandom_range(0, 3) == 0);
            dbg  = ($urandom_range(0, 5) == 0);
            res  = ($urandom_range(0, 5) == 0);
            hit  = 4'($urandom);
            hit3 = 9'($urandom);
            step("rand");
        end

        // Asynchronous reset in the middle of a debug drain.
        {br, jmp, ltu, ld, dbg, res} = '0; fr = 1; idr = 1;
        rst = 0; m_reset();
        step("rst_again");
        rst = 1;
        step("boot_reset2");
        step("boot_set2");
        step("first_fetch2");
        dbg = 1;
        step("dbg_req2");
        ld = 1;
        step("drain_ld2");
        hit = 4'b1111;
        #2 rst = 0;
        m_reset();
        #1;
        check("async_rst_pc", 32'(pc), 32'(PC_BOOT));
        check("async_rst_outs",
              32'({fetch, dec, fl_if, fl_id, fl_ex, h_if, h_id, h_ex, ack, tmo, fwd2}), 32'd0);
        step("rst_hold");
        rst = 1; ld = 0; dbg = 0;
        step("boot_reset3");
        step("boot_set3");
        step("first_fetch3");
        check("decode_after_rst", 32'(dec), 32'd1);
        step("decode3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
